// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// parameterisable bubble insertion, branch flush and stall counter.
//
// Ports:
//   Clk, Reset            rising-edge clock, synchronous active-high reset
//   Valid_in              IF/ID holds a real instruction
//   Rs1_num, Rs2_num      source register numbers (also register file ports)
//   Uses_rs1, Uses_rs2    instruction really reads the source
//   Rd_num                destination register number
//   Read_data_1/2, Imm    operands and decoded immediate
//   RegWrite_in .. ALUOp_in  decoded control
//   Flush                 branch taken in EX, kill the ID instruction
//   *_ex                  ID/EX register contents
//   Stall                 combinational hold request for PC and IF/ID
//   Stall_cycles          saturating count of stalled cycles
module id_ex_stage #(
    parameter int LOAD_BUBBLES = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Valid_in,
    input  logic [2:0] Rs1_num,
    input  logic [2:0] Rs2_num,
    input  logic       Uses_rs1,
    input  logic       Uses_rs2,
    input  logic [2:0] Rd_num,
    input  logic [7:0] Read_data_1,
    input  logic [7:0] Read_data_2,
    input  logic [7:0] Imm,
    input  logic       RegWrite_in,
    input  logic       MemRead_in,
    input  logic       MemWrite_in,
    input  logic       ALUSrc_in,
    input  logic [1:0] ALUOp_in,
    input  logic       Flush,
    output logic       Valid_ex,
    output logic [2:0] Rs1_ex,
    output logic [2:0] Rs2_ex,
    output logic [2:0] Rd_ex,
    output logic [7:0] Op1_ex,
    output logic [7:0] Op2_ex,
    output logic [7:0] Imm_ex,
    output logic       RegWrite_ex,
    output logic       MemRead_ex,
    output logic       MemWrite_ex,
    output logic       ALUSrc_ex,
    output logic [1:0] ALUOp_ex,
    output logic       Stall,
    output logic [15:0] Stall_cycles
);

    localparam logic [1:0] BUB_RELOAD = 2'(LOAD_BUBBLES - 1);

    logic       valid_q, valid_d;
    logic [2:0] rs1_q, rs1_d;
    logic [2:0] rs2_q, rs2_d;
    logic [2:0] rd_q, rd_d;
    logic [7:0] op1_q, op1_d;
    logic [7:0] op2_q, op2_d;
    logic [7:0] imm_q, imm_d;
    logic       rw_q, rw_d;
    logic       mr_q, mr_d;
    logic       mw_q, mw_d;
    logic       as_q, as_d;
    logic [1:0] aop_q, aop_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic [15:0] cnt_q, cnt_d;

    logic hit1;
    logic hit2;
    logic hazard;
    logic stall;

    // R0 is writable, so it takes part in the compare like any register.
    assign hit1   = Uses_rs1 & (Rs1_num == rd_q);
    assign hit2   = Uses_rs2 & (Rs2_num == rd_q);
    assign hazard = valid_q & mr_q & Valid_in & (hit1 | hit2);

    // Outstanding bubbles keep the stall alive even if IF/ID goes empty.
    assign stall  = !Flush & (hazard | (bcnt_q != 2'd0));

    always_comb begin
        valid_d = 1'b0;
        rs1_d   = 3'd0;
        rs2_d   = 3'd0;
        rd_d    = 3'd0;
        op1_d   = 8'd0;
        op2_d   = 8'd0;
        imm_d   = 8'd0;
        rw_d    = 1'b0;
        mr_d    = 1'b0;
        mw_d    = 1'b0;
        as_d    = 1'b0;
        aop_d   = 2'd0;
        bcnt_d  = bcnt_q;

        if (Flush) begin
            bcnt_d = 2'd0;
        end else if (stall) begin
            if (bcnt_q == 2'd0) begin
                bcnt_d = BUB_RELOAD;
            end else begin
                bcnt_d = bcnt_q - 2'd1;
            end
        end else begin
            valid_d = Valid_in;
            rs1_d   = Rs1_num;
            rs2_d   = Rs2_num;
            rd_d    = Rd_num;
            op1_d   = Read_data_1;
            op2_d   = Read_data_2;
            imm_d   = Imm;
            rw_d    = Valid_in & RegWrite_in;
            mr_d    = Valid_in & MemRead_in;
            mw_d    = Valid_in & MemWrite_in;
            as_d    = ALUSrc_in;
            aop_d   = ALUOp_in;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= 1'b0;
            rs1_q   <= 3'd0;
            rs2_q   <= 3'd0;
            rd_q    <= 3'd0;
            op1_q   <= 8'd0;
            op2_q   <= 8'd0;
            imm_q   <= 8'd0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            as_q    <= 1'b0;
            aop_q   <= 2'd0;
            bcnt_q  <= 2'd0;
            cnt_q   <= 16'd0;
        end else begin
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            imm_q   <= imm_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            as_q    <= as_d;
            aop_q   <= aop_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Valid_ex     = valid_q;
    assign Rs1_ex       = rs1_q;
    assign Rs2_ex       = rs2_q;
    assign Rd_ex        = rd_q;
    assign Op1_ex       = op1_q;
    assign Op2_ex       = op2_q;
    assign Imm_ex       = imm_q;
    assign RegWrite_ex  = rw_q;
    assign MemRead_ex   = mr_q;
    assign MemWrite_ex  = mw_q;
    assign ALUSrc_ex    = as_q;
    assign ALUOp_ex     = aop_q;
    assign Stall        = stall;
    assign Stall_cycles = cnt_q;

endmodule
